// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through and runs loads/stores
// as little-endian byte-serial transactions against a byte-wide memory controller.
module mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic              ld_i,
    input  logic              st_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_sdata_i,
    output logic              mc_req_o,
    output logic              mc_we_o,
    output logic [ADDR_W-1:0] mc_addr_o,
    output logic [7:0]        mc_wdata_o,
    input  logic [7:0]        mc_rdata_i,
    input  logic              mc_ack_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stallreq_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [1:0]  k;
    logic [31:0] asm_buf;
    logic        legal;
    logic        mem_op;
    logic [1:0]  last_k;
    logic [31:0] load_data;

    always_comb begin
        legal  = 1'b0;
        last_k = 2'd0;
        case (funct3_i)
            3'b000, 3'b100: begin legal = 1'b1; last_k = 2'd0; end
            3'b001, 3'b101: begin legal = 1'b1; last_k = 2'd1; end
            3'b010:         begin legal = 1'b1; last_k = 2'd3; end
            default:        begin legal = 1'b0; last_k = 2'd0; end
        endcase
    end

    assign mem_op = (ld_i | st_i) & legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (mem_op) next_state = BUSY;
            BUSY:    if (mc_ack_i && (k == last_k)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Byte counter and assembly register; cleared every IDLE cycle so no stale byte survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= 2'd0;
            asm_buf <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    k       <= 2'd0;
                    asm_buf <= 32'd0;
                end
                BUSY: begin
                    if (mc_ack_i) begin
                        if (ld_i) asm_buf[{k, 3'b000} +: 8] <= mc_rdata_i;
                        if (k != last_k) k <= k + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (funct3_i)
            3'b000:  load_data = {{24{asm_buf[7]}}, asm_buf[7:0]};
            3'b001:  load_data = {{16{asm_buf[15]}}, asm_buf[15:0]};
            3'b100:  load_data = {24'd0, asm_buf[7:0]};
            3'b101:  load_data = {16'd0, asm_buf[15:0]};
            default: load_data = asm_buf;
        endcase
    end

    // Reset gates every output combinationally so a mid-transaction reset drops the request at once.
    always_comb begin
        mc_req_o   = 1'b0;
        mc_we_o    = 1'b0;
        mc_addr_o  = '0;
        mc_wdata_o = 8'd0;
        wd_o       = 5'd0;
        wreg_o     = 1'b0;
        wdata_o    = 32'd0;
        stallreq_o = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    wd_o = wd_i;
                    if (ld_i || st_i) begin
                        stallreq_o = legal;
                    end else begin
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end
                end
                BUSY: begin
                    wd_o       = wd_i;
                    mc_req_o   = 1'b1;
                    mc_we_o    = st_i;
                    mc_addr_o  = mem_addr_i[ADDR_W-1:0] + ADDR_W'(k);
                    mc_wdata_o = mem_sdata_i[{k, 3'b000} +: 8];
                    stallreq_o = 1'b1;
                end
                DONE: begin
                    wd_o = wd_i;
                    if (ld_i) begin
                        wreg_o  = wreg_i;
                        wdata_o = load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access with a byte-wide memory controller
// model that acks after a programmable number of wait cycles and logs every byte.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        ld_i;
    logic        st_i;
    logic [2:0]  funct3_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic        mc_req_o;
    logic        mc_we_o;
    logic [31:0] mc_addr_o;
    logic [7:0]  mc_wdata_o;
    logic [7:0]  mc_rdata_i;
    logic        mc_ack_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;

    mem_access #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .ld_i(ld_i), .st_i(st_i), .funct3_i(funct3_i),
        .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
        .mc_req_o(mc_req_o), .mc_we_o(mc_we_o), .mc_addr_o(mc_addr_o),
        .mc_wdata_o(mc_wdata_o), .mc_rdata_i(mc_rdata_i), .mc_ack_i(mc_ack_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Controller model state
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          log_n     = 0;
    int          req_cycles = 0;
    int          rd_base   = 0;
    logic [7:0]  rd_bytes [0:3];
    logic [31:0] log_addr  [0:63];
    logic        log_we    [0:63];
    logic [7:0]  log_wdata [0:63];

    // Per-op observations
    int          cyc;
    int          stl;
    logic [31:0] wdv;
    logic        wrv;
    logic [4:0]  wdr;
    int          base;
    int          reqs0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        ld_i        = ld;
        st_i        = st;
        funct3_i    = f3;
        mem_addr_i  = addr;
        mem_sdata_i = sdata;
        wd_i        = wd;
        wreg_i      = wreg;
        wdata_i     = wdata;
    endtask

    // Runs from the IDLE cycle until the first cycle with stall low (the DONE cycle).
    task automatic runOp(output int cycles, output int stalls, output logic [31:0] wdata_seen,
                         output logic wreg_seen, output logic [4:0] wd_seen);
        logic done;
        done       = 1'b0;
        cycles     = 0;
        stalls     = 0;
        wdata_seen = 32'd0;
        wreg_seen  = 1'b0;
        wd_seen    = 5'd0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (stallreq_o) begin
                stalls++;
            end else begin
                done       = 1'b1;
                wdata_seen = wdata_o;
                wreg_seen  = wreg_o;
                wd_seen    = wd_o;
            end
        end
        checkOutput("op_finished", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Memory controller: decides ack for the current cycle shortly after each rising edge.
    always begin
        @(posedge clk);
        #2;
        if (mc_req_o) req_cycles++;
        if (rst || !mc_req_o) begin
            mc_ack_i = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= ack_delay) begin
            mc_ack_i   = 1'b1;
            mc_rdata_i = rd_bytes[(log_n - rd_base) & 3];
            if (log_n < 64) begin
                log_addr[log_n]  = mc_addr_o;
                log_we[log_n]    = mc_we_o;
                log_wdata[log_n] = mc_wdata_o;
                log_n++;
            end
            wait_cnt = 0;
        end else begin
            mc_ack_i = 1'b0;
            wait_cnt++;
        end
    end

    initial begin
        rst        = 1'b1;
        mc_ack_i   = 1'b0;
        mc_rdata_i = 8'd0;
        for (int i = 0; i < 4; i++) rd_bytes[i] = 8'd0;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd5, 1'b1, 32'h1234);

        // Reset: outputs forced to zero even with a live pass-through op present
        repeat (2) @(negedge clk);
        checkOutput("rst_mc_req",  {31'd0, mc_req_o}, 32'd0);
        checkOutput("rst_mc_addr", mc_addr_o, 32'd0);
        checkOutput("rst_stall",   {31'd0, stallreq_o}, 32'd0);
        checkOutput("rst_wreg",    {31'd0, wreg_o}, 32'd0);
        checkOutput("rst_wd",      {27'd0, wd_o}, 32'd0);
        checkOutput("rst_wdata",   wdata_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Non-memory pass-through
        reqs0 = req_cycles;
        @(negedge clk);
        checkOutput("pass_wd",    {27'd0, wd_o}, 32'd5);
        checkOutput("pass_wreg",  {31'd0, wreg_o}, 32'd1);
        checkOutput("pass_wdata", wdata_o, 32'h1234);
        checkOutput("pass_stall", {31'd0, stallreq_o}, 32'd0);
        @(negedge clk);
        checkOutput("pass_noreq", req_cycles - reqs0, 32'd0);
        @(posedge clk);
        #1;

        // LW at 0x100, immediate acks
        ack_delay = 0;
        rd_base = log_n;
        rd_bytes[0] = 8'h78; rd_bytes[1] = 8'h56; rd_bytes[2] = 8'h34; rd_bytes[3] = 8'h12;
        base = log_n;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd3, 1'b1, 32'hDEAD);
        runOp(cyc, stl, wdv, wrv, wdr);
        checkOutput("lw_latency", cyc, 32'd6);
        checkOutput("lw_stalls",  stl, 32'd5);
        checkOutput("lw_wdata",   wdv, 32'h12345678);
        checkOutput("lw_wreg",    {31'd0, wrv}, 32'd1);
        checkOutput("lw_wd",      {27'd0, wdr}, 32'd3);
        checkOutput("lw_nbytes",  log_n - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("lw_addr", log_addr[base+i], 32'h100 + i);
            checkOutput("lw_we",   {31'd0, log_we[base+i]}, 32'd0);
        end

        // LB / LBU at 0x7 with byte 0x80
        rd_base = log_n;
        rd_bytes[0] = 8'h80;
        base = log_n;
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h7, 32'd0, 5'd4, 1'b1, 32'd0);
        runOp(cyc, stl, wdv, wrv, wdr);
        checkOutput("lb_latency", cyc, 32'd3);
        checkOutput("lb_wdata",   wdv, 32'hFFFFFF80);
        checkOutput("lb_addr",    log_addr[base], 32'h7);
        rd_base = log_n;
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h7, 32'd0, 5'd4, 1'b1, 32'd0);
        runOp(cyc, stl, wdv, wrv, wdr);
        checkOutput("lbu_wdata",  wdv, 32'h00000080);

        // LH with bytes 0x01, 0x80
        rd_base = log_n;
        rd_bytes[0] = 8'h01; rd_bytes[1] = 8'h80;
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h20, 32'd0, 5'd6, 1'b1, 32'd0);
        runOp(cyc, stl, wdv, wrv, wdr);
        checkOutput("lh_latency", cyc, 32'd4);
        checkOutput("lh_wdata",   wdv, 32'hFFFF8001);

        // SH across the address wrap with 2 wait cycles per byte
        ack_delay = 2;
        base = log_n;
        applyStimulus(1'b0, 1'b1, 3'b001, 32'hFFFFFFFF, 32'hAABBCCDD, 5'd8, 1'b1, 32'h55);
        runOp(cyc, stl, wdv, wrv, wdr);
        checkOutput("sh_latency", cyc, 32'd8);
        checkOutput("sh_stalls",  stl, 32'd7);
        checkOutput("sh_wreg",    {31'd0, wrv}, 32'd0);
        checkOutput("sh_wdata",   wdv, 32'd0);
        checkOutput("sh_nbytes",  log_n - base, 32'd2);
        checkOutput("sh_addr0",   log_addr[base], 32'hFFFFFFFF);
        checkOutput("sh_data0",   {24'd0, log_wdata[base]}, 32'hDD);
        checkOutput("sh_we0",     {31'd0, log_we[base]}, 32'd1);
        checkOutput("sh_addr1",   log_addr[base+1], 32'h0);
        checkOutput("sh_data1",   {24'd0, log_wdata[base+1]}, 32'hCC);
        checkOutput("sh_we1",     {31'd0, log_we[base+1]}, 32'd1);

        // Reset asserted during the third byte of an LW
        ack_delay = 0;
        rd_base = log_n;
        rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 5'd7, 1'b1, 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        checkOutput("mid_req_before", {31'd0, mc_req_o}, 32'd1);
        checkOutput("mid_addr_before", mc_addr_o, 32'h202);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_req",   {31'd0, mc_req_o}, 32'd0);
        checkOutput("mid_rst_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_base = log_n;
        rd_bytes[0] = 8'h9C;
        base = log_n;
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h40, 32'd0, 5'd9, 1'b1, 32'd0);
        runOp(cyc, stl, wdv, wrv, wdr);
        checkOutput("post_rst_latency", cyc, 32'd3);
        checkOutput("post_rst_wdata",   wdv, 32'hFFFFFF9C);
        checkOutput("post_rst_nbytes",  log_n - base, 32'd1);
        checkOutput("post_rst_addr",    log_addr[base], 32'h40);

        // Illegal funct3 on a load: no access, no stall, no write-back
        reqs0 = req_cycles;
        applyStimulus(1'b1, 1'b0, 3'b011, 32'h300, 32'd0, 5'd10, 1'b1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("illegal_stall", {31'd0, stallreq_o}, 32'd0);
            checkOutput("illegal_wreg",  {31'd0, wreg_o}, 32'd0);
        end
        checkOutput("illegal_noreq", req_cycles - reqs0, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back SB then LB
        base = log_n;
        reqs0 = req_cycles;
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h10, 32'h123456EE, 5'd11, 1'b1, 32'd0);
        runOp(cyc, stl, wdv, wrv, wdr);
        checkOutput("sb_latency", cyc, 32'd3);
        checkOutput("sb_wreg",    {31'd0, wrv}, 32'd0);
        rd_base = log_n;
        rd_bytes[0] = 8'h7F;
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h11, 32'd0, 5'd12, 1'b1, 32'd0);
        runOp(cyc, stl, wdv, wrv, wdr);
        checkOutput("b2b_lb_latency", cyc, 32'd3);
        checkOutput("b2b_lb_wdata",   wdv, 32'h0000007F);
        checkOutput("b2b_nbytes",     log_n - base, 32'd2);
        checkOutput("b2b_req_cycles", req_cycles - reqs0, 32'd2);
        checkOutput("b2b_addr0",      log_addr[base], 32'h10);
        checkOutput("b2b_we0",        {31'd0, log_we[base]}, 32'd1);
        checkOutput("b2b_data0",      {24'd0, log_wdata[base]}, 32'hEE);
        checkOutput("b2b_addr1",      log_addr[base+1], 32'h11);
        checkOutput("b2b_we1",        {31'd0, log_we[base+1]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 5-stage RISC-V pipeline; consumes the instruction held in the EX/MEM latch and produces the write-back triple for MEM/WB. Non-memory instructions pass through combinationally. Loads and stores are executed as a byte-serial transaction with the byte-wide memory controller, little-endian. While a transaction is in flight, the stage raises a stall request to ctrl so the EX/MEM latch holds its contents stable.

## Interface
- ADDR_W, 32, memory-controller address width; addresses wrap modulo 2^ADDR_W.
- clk  in  1  system clock; rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- wd_i  in  5  destination register from EX/MEM.
- wreg_i  in  1  register-write enable from EX/MEM.
- wdata_i  in  32  ALU result from EX/MEM; passed through for non-memory ops.
- ld_i  in  1  instruction is a load.
- st_i  in  1  instruction is a store; ld_i and st_i are never both 1.
- funct3_i  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_addr_i  in  32  effective byte address.
- mem_sdata_i  in  32  store data; low N bytes are used.
- mc_req_o  out  1  byte request to the memory controller.
- mc_we_o  out  1  1 = write byte, 0 = read byte.
- mc_addr_o  out  ADDR_W  byte address.
- mc_wdata_o  out  8  write byte.
- mc_rdata_i  in  8  read byte; valid in the mc_ack_i cycle.
- mc_ack_i  in  1  current byte completed.
- wd_o  out  5  write-back register index.
- wreg_o  out  1  write-back enable.
- wdata_o  out  32  write-back data.
- stallreq_o  out  1  stall request to ctrl.

## Operation
- Byte count N: B/BU → 1, H/HU → 2, W → 4.
- Illegal funct3 (011, 110, 111) with ld_i or st_i set:
  - no memory access;
  - wreg_o = 0, stallreq_o = 0.
- FSM states IDLE, BUSY, DONE; byte counter k (0..3); 32-bit assembly register buf.
- IDLE:
  - Non-memory op: wd_o = wd_i, wreg_o = wreg_i, wdata_o = wdata_i, stallreq_o = 0.
  - Legal memory op: stallreq_o = 1, wreg_o = 0; next state BUSY with k = 0, buf = 0.
- BUSY:
  - Outputs: mc_req_o = 1, mc_addr_o = mem_addr_i[ADDR_W-1:0] + k (wrapping), mc_we_o = st_i, mc_wdata_o = mem_sdata_i byte k; stallreq_o = 1, wreg_o = 0.
  - On mc_ack_i with a load: buf byte k ← mc_rdata_i.
  - On mc_ack_i with k = N-1: go to DONE.
  - On mc_ack_i otherwise: k ← k+1.
  - Without ack: hold all outputs unchanged.
- DONE:
  - stallreq_o = 0, mc_req_o = 0; next state IDLE unconditionally.
  - Load: wd_o = wd_i, wreg_o = wreg_i, wdata_o = buf sign-extended (B, H) or zero-extended (BU, HU, W uses all 32 bits).
  - Store: wreg_o = 0, wdata_o = 0.
- The DONE→IDLE edge coincides with EX/MEM advancing, so a following memory op is seen fresh in IDLE. Back-to-back memory ops are legal.
- Misaligned addresses are legal; there is no alignment trap.
- mc_req_o is 0 in IDLE and DONE.

## Timing
- Reset values (asserted asynchronously, immediately): state IDLE, k = 0, buf = 0, mc_req_o = 0, mc_we_o = 0, mc_addr_o = 0, mc_wdata_o = 0.
- Outputs while in reset: stallreq_o = 0, wreg_o = 0, wd_o = 0, wdata_o = 0.
- Reset mid-transaction: the partial transaction is discarded and mc_req_o drops within the reset cycle.
- mc_ack_i may arrive in the first BUSY cycle. mc_ack_i outside BUSY is ignored.
- Minimum latency of a memory op is N+2 cycles:
  - 1 IDLE cycle, N BUSY cycles, 1 DONE cycle;
  - stallreq_o is high for N+1 cycles.
- Each cycle without an ack in BUSY adds 1 cycle.
- Inputs are required stable from IDLE through DONE; the block does not latch them.

## Test plan
- Non-memory op, wd_i = 5, wreg_i = 1, wdata_i = 0x1234 → same values on outputs in the same cycle; stallreq_o = 0; mc_req_o never asserted.
- LW at 0x100, controller returns 0x78, 0x56, 0x34, 0x12 with immediate acks → addresses 0x100..0x103 in order; wdata_o = 0x12345678 in DONE (cycle 6); stallreq_o high for exactly 5 cycles.
- LB at 0x7, byte 0x80 → wdata_o = 0xFFFFFF80. LBU at 0x7, byte 0x80 → 0x00000080. LH with bytes 0x01, 0x80 → 0xFFFF8001.
- SH at 0xFFFFFFFF, sdata 0xAABBCCDD, ack delayed 2 cycles per byte → writes 0xDD to 0xFFFFFFFF, then 0xCC to 0x00000000; mc_we_o = 1; wreg_o = 0; total latency 8 cycles.
- Assert rst during the 3rd byte of an LW → mc_req_o = 0 and stallreq_o = 0 immediately. After release, a new LB completes normally with no stale byte carried over.
- ld_i = 1, funct3 = 011 → no mc_req_o, wreg_o = 0, stallreq_o = 0. Back-to-back SB then LB → two separate transactions with no dropped or duplicated request.
